// File: rtl/i2c_target_regs.sv
// I2C target answering one 7-bit address with a byte-wide register bank behind an
// auto-incrementing pointer; supports pointer writes, data writes and sequential reads.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NREGS       = 16,
    localparam int        IW          = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oen_o,
    input  logic [IW-1:0] reg_idx_i,
    output logic [7:0]    reg_data_o,
    output logic          wr_stb_o,
    output logic [IW-1:0] wr_idx_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_BYTE  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_BYTE  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;

    logic [1:0]    scl_sync_reg, sda_sync_reg;
    logic          scl_hist_reg, sda_hist_reg;
    logic          scl_rise_reg, scl_fall_reg, start_reg, stop_reg;
    logic [2:0]    state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [IW-1:0] ptr_reg;
    logic          first_byte_reg, rw_reg;
    logic [7:0]    regs [NREGS];
    logic [7:0]    rd_byte;
    logic          wr_fire;

    assign sda_o      = 1'b0;
    assign reg_data_o = regs[reg_idx_i];
    assign rd_byte    = regs[ptr_reg];
    assign wr_fire    = (state_reg == S_WR_BYTE) && scl_fall_reg && (bit_cnt_reg == 4'd8)
                        && !first_byte_reg && !start_reg && !stop_reg;

    // Edge and bus-condition pulses are registered so every FSM action lands a fixed
    // four cycles after the pad transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
            scl_rise_reg <= 1'b0;
            scl_fall_reg <= 1'b0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl_i};
            sda_sync_reg <= {sda_sync_reg[0], sda_i};
            scl_hist_reg <= scl_sync_reg[1];
            sda_hist_reg <= sda_sync_reg[1];
            scl_rise_reg <= scl_sync_reg[1] & ~scl_hist_reg;
            scl_fall_reg <= ~scl_sync_reg[1] & scl_hist_reg;
            start_reg    <= scl_sync_reg[1] & scl_hist_reg & sda_hist_reg & ~sda_sync_reg[1];
            stop_reg     <= scl_sync_reg[1] & scl_hist_reg & ~sda_hist_reg & sda_sync_reg[1];
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [7:0] val_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i)
                val_reg <= 8'h00;
            else if (wr_fire && (ptr_reg == IW'(gi)))
                val_reg <= shift_reg;
        end
        assign regs[gi] = val_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            ptr_reg        <= '0;
            first_byte_reg <= 1'b0;
            rw_reg         <= 1'b0;
            sda_oen_o      <= 1'b0;
            busy_o         <= 1'b0;
            wr_stb_o       <= 1'b0;
            wr_idx_o       <= '0;
            wr_data_o      <= 8'h00;
        end else begin
            wr_stb_o <= 1'b0;
            if (stop_reg) begin
                state_reg   <= S_IDLE;
                bit_cnt_reg <= 4'd0;
                sda_oen_o   <= 1'b0;
                busy_o      <= 1'b0;
            end else if (start_reg) begin
                state_reg   <= S_ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oen_o   <= 1'b0;
                busy_o      <= 1'b0;
            end else begin
                case (state_reg)
                    S_ADDR: begin
                        if (scl_rise_reg && bit_cnt_reg != 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda_hist_reg};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall_reg && bit_cnt_reg == 4'd8) begin
                            bit_cnt_reg <= 4'd0;
                            if (shift_reg[7:1] == TARGET_ADDR) begin
                                sda_oen_o <= 1'b1;
                                busy_o    <= 1'b1;
                                rw_reg    <= shift_reg[0];
                                state_reg <= S_ADDR_ACK;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall_reg) begin
                            if (rw_reg) begin
                                // First read bit goes out on the same fall that ends the ACK.
                                sda_oen_o   <= ~rd_byte[7];
                                shift_reg   <= {rd_byte[6:0], 1'b0};
                                bit_cnt_reg <= 4'd1;
                                state_reg   <= S_RD_BYTE;
                            end else begin
                                sda_oen_o      <= 1'b0;
                                first_byte_reg <= 1'b1;
                                bit_cnt_reg    <= 4'd0;
                                state_reg      <= S_WR_BYTE;
                            end
                        end
                    end
                    S_WR_BYTE: begin
                        if (scl_rise_reg && bit_cnt_reg != 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda_hist_reg};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall_reg && bit_cnt_reg == 4'd8) begin
                            sda_oen_o   <= 1'b1;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= S_WR_ACK;
                            if (first_byte_reg) begin
                                ptr_reg        <= shift_reg[IW-1:0];
                                first_byte_reg <= 1'b0;
                            end else begin
                                wr_stb_o  <= 1'b1;
                                wr_idx_o  <= ptr_reg;
                                wr_data_o <= shift_reg;
                                ptr_reg   <= ptr_reg + IW'(1);
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall_reg) begin
                            sda_oen_o <= 1'b0;
                            state_reg <= S_WR_BYTE;
                        end
                    end
                    S_RD_BYTE: begin
                        if (scl_fall_reg) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oen_o   <= 1'b0;
                                ptr_reg     <= ptr_reg + IW'(1);
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= S_RD_ACK;
                            end else begin
                                sda_oen_o   <= ~shift_reg[7];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise_reg) begin
                            if (!sda_hist_reg) begin
                                shift_reg   <= rd_byte;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= S_RD_BYTE;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs: a bit-banged I2C master plus a register/pointer
// model that predicts every written event and every byte read back.
module tb_i2c_target_regs;
    localparam int NREGS = 16;
    localparam int IW    = 4;
    localparam int Q     = 4;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl_drv = 1'b1;
    logic          sda_drv = 1'b1;
    logic          sda_bus;
    logic          sda_o, sda_oen, wr_stb, busy;
    logic [IW-1:0] reg_idx = '0;
    logic [IW-1:0] wr_idx;
    logic [7:0]    reg_data, wr_data;

    int checks = 0;
    int failures = 0;
    int got_q[$];
    int exp_q[$];
    logic [7:0] m_regs [NREGS];
    int m_ptr = 0;
    bit oen_seen = 0;
    bit busy_seen = 0;

    assign sda_bus = sda_drv & ~sda_oen;

    i2c_target_regs #(.TARGET_ADDR(7'h50), .NREGS(NREGS)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_drv), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen_o(sda_oen), .reg_idx_i(reg_idx), .reg_data_o(reg_data),
        .wr_stb_o(wr_stb), .wr_idx_o(wr_idx), .wr_data_o(wr_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) got_q.push_back(int'(wr_idx) * 256 + int'(wr_data));
        if (sda_oen) oen_seen = 1;
        if (busy) busy_seen = 1;
    end

    // Reference model: pointer byte selects the register, each data byte lands at the
    // pointer and advances it modulo NREGS; reads advance it the same way.
    function automatic void m_write(input logic [7:0] p, input byte_q_t d);
        m_ptr = int'(p) % NREGS;
        foreach (d[i]) begin
            m_regs[m_ptr] = d[i];
            exp_q.push_back(m_ptr * 256 + int'(d[i]));
            m_ptr = (m_ptr + 1) % NREGS;
        end
    endfunction

    function automatic byte_q_t m_read(input int n);
        byte_q_t r;
        for (int i = 0; i < n; i++) begin
            r.push_back(m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREGS;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(Q);
        tick(2);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; tick(Q);
        scl_drv = 1'b1; tick(2 * Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        b = sda_bus; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic ack_bit(input logic b, output logic oen_high);
        sda_drv = b; tick(Q);
        scl_drv = 1'b1; tick(Q);
        oen_high = sda_oen; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            b[i] = bt;
        end
    endtask

    task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input byte_q_t d,
                             output int nacks);
        logic ack;
        nacks = 0;
        bus_start();
        send_byte({a, 1'b0}, ack); nacks += int'(ack);
        send_byte(p, ack);         nacks += int'(ack);
        foreach (d[i]) begin
            send_byte(d[i], ack);  nacks += int'(ack);
        end
        bus_stop();
    endtask

    task automatic read_txn(input logic [6:0] a, input int n, output byte_q_t got,
                            output int nacks);
        logic ack, oh;
        logic [7:0] b;
        got = {};
        bus_start();
        send_byte({a, 1'b1}, ack);
        nacks = int'(ack);
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            got.push_back(b);
            ack_bit((i == n - 1) ? 1'b1 : 1'b0, oh);
        end
        bus_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (sda_oen !== 1'b0) begin failures++; $display("FAIL reset_oen got=%b exp=0", sda_oen); end
        checks++; if (sda_o !== 1'b0) begin failures++; $display("FAIL reset_sda_o got=%b exp=0", sda_o); end
        checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr_idx !== '0 || wr_data !== 8'h00) begin
            failures++; $display("FAIL reset_wr_bus got=%0h/%0h exp=0/0", wr_idx, wr_data); end
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 8'h00;
            reg_idx = IW'(i); #1;
            checks++; if (reg_data !== 8'h00) begin
                failures++; $display("FAIL reset_reg%0d got=%h exp=00", i, reg_data); end
        end
        m_ptr = 0;
        tick(2);
        $display("test_reset done");
    endtask

    task automatic test_write_burst();
        logic ack;
        logic [7:0] d;
        byte_q_t dq;
        got_q.delete(); exp_q.delete();
        dq = '{8'hA5, 8'h5A};
        m_write(8'h03, dq);
        bus_start();
        send_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL burst_addr_ack got=%b exp=0", ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy got=%b exp=1", busy); end
        send_byte(8'h03, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL burst_ptr_ack got=%b exp=0", ack); end
        foreach (dq[i]) begin
            send_byte(dq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL burst_data%0d_ack got=%b exp=0", i, ack); end
        end
        bus_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy_after_stop got=%b exp=0", busy); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL burst_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL burst_wr%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 3; i <= 4; i++) begin
            reg_idx = IW'(i); #1;
            d = m_regs[i];
            checks++; if (reg_data !== d) begin
                failures++; $display("FAIL burst_reg%0d got=%h exp=%h", i, reg_data, d); end
        end
        $display("test_write_burst done writes=%0d", got_q.size());
    endtask

    task automatic test_read_rsta();
        logic ack, oh;
        logic [7:0] b0, b1, r5;
        byte_q_t dq, exp_rd, got;
        int nacks;
        r5 = 8'($urandom);
        dq = '{r5};
        write_txn(7'h50, 8'h05, dq, nacks);
        m_write(8'h05, dq);
        got_q.delete(); exp_q.delete();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        m_write(8'h03, '{});
        bus_start();
        send_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        recv_byte(b0);
        ack_bit(1'b0, oh);
        recv_byte(b1);
        ack_bit(1'b1, oh);
        bus_stop();
        exp_rd = m_read(2);
        checks++; if (b0 !== exp_rd[0] || b0 !== 8'hA5) begin
            failures++; $display("FAIL rd_byte0 got=%h exp=%h", b0, exp_rd[0]); end
        checks++; if (b1 !== exp_rd[1] || b1 !== 8'h5A) begin
            failures++; $display("FAIL rd_byte1 got=%h exp=%h", b1, exp_rd[1]); end
        checks++; if (oh !== 1'b0) begin failures++; $display("FAIL rd_nack_released got=%b exp=0", oh); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rd_no_write got=%0d exp=0", got_q.size()); end
        read_txn(7'h50, 1, got, nacks);
        exp_rd = m_read(1);
        checks++; if (got[0] !== exp_rd[0]) begin
            failures++; $display("FAIL rd_ptr_after got=%h exp=%h", got[0], exp_rd[0]); end
        $display("test_read_rsta done bytes=%h %h next=%h", b0, b1, got[0]);
    endtask

    task automatic test_addr_mismatch();
        logic [6:0] a;
        int nacks;
        for (int t = 0; t < 2; t++) begin
            a = (t == 0) ? 7'h51 : 7'($urandom);
            if (a == 7'h50) a = 7'h2A;
            got_q.delete();
            oen_seen = 0; busy_seen = 0;
            write_txn(a, (t == 0) ? 8'h00 : 8'($urandom), '{8'($urandom)}, nacks);
            checks++; if (oen_seen !== 1'b0) begin failures++; $display("FAIL mismatch%0d_oen got=1 exp=0", t); end
            checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL mismatch%0d_busy got=1 exp=0", t); end
            checks++; if (got_q.size() != 0) begin
                failures++; $display("FAIL mismatch%0d_write got=%0d exp=0", t, got_q.size()); end
            checks++; if (nacks != 3) begin failures++; $display("FAIL mismatch%0d_nacks got=%0d exp=3", t, nacks); end
            $display("test_addr_mismatch addr=%h done", a);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] p;
        byte_q_t dq, got, exp_rd;
        int nacks;
        got_q.delete(); exp_q.delete();
        p = {4'($urandom), 4'hF};
        dq = '{8'h11, 8'h22, 8'h33};
        write_txn(7'h50, p, dq, nacks);
        m_write(p, dq);
        checks++; if (nacks != 0) begin failures++; $display("FAIL wrap_nacks got=%0d exp=0", nacks); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL wrap_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL wrap_wr%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        write_txn(7'h50, 8'h0F, '{}, nacks);
        m_write(8'h0F, '{});
        read_txn(7'h50, 1, got, nacks);
        exp_rd = m_read(1);
        checks++; if (got[0] !== exp_rd[0] || got[0] !== 8'h11) begin
            failures++; $display("FAIL wrap_read got=%h exp=%h", got[0], exp_rd[0]); end
        $display("test_wrap done ptr=%h read=%h", p, got[0]);
    endtask

    task automatic test_stop_abort();
        logic ack;
        logic [7:0] p, a;
        byte_q_t dq;
        got_q.delete(); exp_q.delete();
        p = 8'($urandom);
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(p, ack);
        m_write(p, '{});
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        bus_stop();
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL abort_write got=%0d exp=0", got_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        a = 8'hA0;
        bus_start();
        for (int i = 7; i >= 1; i--) send_bit(a[i]);
        sda_drv = a[0]; tick(Q);
        scl_drv = 1'b1; tick(2 * Q);
        scl_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sda_oen !== 1'b0) begin failures++; $display("FAIL ack_timing_early got=%b exp=0", sda_oen); end
        @(posedge clk);
        #1;
        checks++; if (sda_oen !== 1'b1) begin failures++; $display("FAIL ack_timing_edge got=%b exp=1", sda_oen); end
        @(negedge clk);
        recv_bit(ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL abort_next_ack got=%b exp=0", ack); end
        p = 8'($urandom);
        dq = '{8'($urandom)};
        send_byte(p, ack);
        send_byte(dq[0], ack);
        bus_stop();
        m_write(p, dq);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL abort_next_write got=%0d/%h exp=1/%h", got_q.size(),
                                 (got_q.size() > 0) ? got_q[0] : -1, exp_q[0]); end
        $display("test_stop_abort done");
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic [7:0] k, d;
        byte_q_t dq;
        int n, nacks;
        k = 8'($urandom_range(0, NREGS - 1));
        d = 8'($urandom) & 8'h7F;
        write_txn(7'h50, k, '{d}, nacks);
        m_write(k, '{d});
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(k, ack);
        bus_start();
        send_byte(8'hA1, ack);
        n = 0;
        while (sda_oen !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (sda_oen !== 1'b1) begin failures++; $display("FAIL rstrd_driving got=%b exp=1", sda_oen); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sda_oen !== 1'b0) begin failures++; $display("FAIL rstrd_release got=%b exp=0", sda_oen); end
        @(negedge clk);
        sda_drv = 1'b1; tick(2);
        scl_drv = 1'b1; tick(2);
        rst = 1'b0; tick(2);
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        for (int i = 0; i < NREGS; i++) begin
            reg_idx = IW'(i); #1;
            checks++; if (reg_data !== m_regs[i]) begin
                failures++; $display("FAIL rstrd_reg%0d got=%h exp=%h", i, reg_data, m_regs[i]); end
        end
        got_q.delete(); exp_q.delete();
        k = 8'($urandom);
        dq = '{8'($urandom), 8'($urandom)};
        write_txn(7'h50, k, dq, nacks);
        m_write(k, dq);
        checks++; if (nacks != 0) begin failures++; $display("FAIL rstrd_nacks got=%0d exp=0", nacks); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rstrd_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rstrd_wr%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        $display("test_reset_mid_read done");
    endtask

    task automatic test_random();
        logic [7:0] p;
        byte_q_t dq, got, exp_rd;
        int n, nacks;
        for (int t = 0; t < 3; t++) begin
            got_q.delete(); exp_q.delete();
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            dq = {};
            for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
            write_txn(7'h50, p, dq, nacks);
            m_write(p, dq);
            checks++; if (nacks != 0) begin failures++; $display("FAIL rand%0d_nacks got=%0d exp=0", t, nacks); end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", t, got_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++; if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand%0d_wr%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]); end
            end
            p = 8'($urandom);
            write_txn(7'h50, p, '{}, nacks);
            m_write(p, '{});
            n = $urandom_range(1, 5);
            read_txn(7'h50, n, got, nacks);
            exp_rd = m_read(n);
            foreach (exp_rd[i]) begin
                checks++; if (got[i] !== exp_rd[i]) begin
                    failures++; $display("FAIL rand%0d_rd%0d got=%h exp=%h", t, i, got[i], exp_rd[i]); end
            end
            $display("test_random iter=%0d ptr=%h reads=%0d", t, p, n);
        end
        for (int i = 0; i < NREGS; i++) begin
            reg_idx = IW'(i); #1;
            checks++; if (reg_data !== m_regs[i]) begin
                failures++; $display("FAIL rand_local_reg%0d got=%h exp=%h", i, reg_data, m_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_rsta();
        test_addr_mismatch();
        test_wrap();
        test_stop_abort();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
